// File: rtl/ssd_host_initiator.sv
// Host-side initiator: takes one command at a time, strobes the SSD controller,
// waits for completion or timeout, and returns a response with statistics.
module ssd_host_initiator #(
   parameter int N              = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 2048,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [N-1:0]          req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  ssd_read,
   output logic                  ssd_write,
   output logic [N-1:0]          ssd_addr,
   output logic [DATA_WIDTH-1:0] ssd_wdata,
   input  logic                  ssd_ready,
   input  logic                  ssd_busy,
   input  logic [DATA_WIDTH-1:0] ssd_rdata,
   output logic [CNT_W-1:0]      rd_count,
   output logic [CNT_W-1:0]      wr_count,
   output logic [CNT_W-1:0]      err_count,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam int             TW    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_next;
   logic                  r_write;
   logic [N-1:0]          r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic [TW-1:0]         r_timer;
   logic [CNT_W-1:0]      r_rd_cnt;
   logic [CNT_W-1:0]      r_wr_cnt;
   logic [CNT_W-1:0]      r_err_cnt;

   logic w_accept;
   logic w_strobe;
   logic w_done;
   logic w_timeout;
   logic w_active;

   // Both ports are valid/ready: a transfer happens on any cycle where valid and
   // ready are both high; rsp_valid/rsp_rdata/rsp_err stay stable until then.
   always_comb begin
      w_accept  = 1'b0;
      w_strobe  = 1'b0;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      w_next    = r_state;
      case (r_state)
         S_IDLE: begin
            w_accept = req_valid;
            if (req_valid) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_strobe = !ssd_busy;
            if (!ssd_busy) w_next = S_WAIT;
         end
         S_WAIT: begin
            // Completion beats timeout when both land on the last cycle.
            w_done    = ssd_ready;
            w_timeout = !ssd_ready && (r_timer == TLAST);
            if (ssd_ready || (r_timer == TLAST)) w_next = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_timer   <= '0;
         r_rd_cnt  <= '0;
         r_wr_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_strobe) begin
            r_timer <= '0;
         end else if (r_state == S_WAIT) begin
            r_timer <= r_timer + TW'(1);
         end
         if (w_done) begin
            r_rdata <= r_write ? '0 : ssd_rdata;
            r_err   <= 1'b0;
            if (r_write) begin
               if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end else begin
               if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
         end
         if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
      end
   end

   assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = rsp_valid ? r_rdata : '0;
   assign rsp_err   = rsp_valid && r_err;
   assign ssd_read  = w_strobe && !r_write;
   assign ssd_write = w_strobe && r_write;
   assign ssd_addr  = w_active ? r_addr : '0;
   assign ssd_wdata = w_active ? r_wdata : '0;
   assign rd_count  = r_rd_cnt;
   assign wr_count  = r_wr_cnt;
   assign err_count = r_err_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ssd_host_initiator.sv
// Bench for ssd_host_initiator: directed vector table, reset/saturation sequences
// and randomized commands scored against a transaction-level reference model.
module tb_ssd_host_initiator;

   localparam int T   = 1024;
   localparam int CW  = 2;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          ssd_read, ssd_write, ssd_ready, ssd_busy;
   logic [31:0]   ssd_addr, ssd_wdata, ssd_rdata;
   logic [CW-1:0] rd_count, wr_count, err_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   ssd_host_initiator #(
      .N(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ssd_read(ssd_read), .ssd_write(ssd_write), .ssd_addr(ssd_addr), .ssd_wdata(ssd_wdata),
      .ssd_ready(ssd_ready), .ssd_busy(ssd_busy), .ssd_rdata(ssd_rdata),
      .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
      .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] ssd_mem[logic [31:0]];
   int m_rd, m_wr, m_err;

   // SSD controller model state
   bit          pend;
   int          left;
   logic        pend_wr;
   logic [31:0] pend_addr, pend_wd;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      int          lat;     // cycles from strobe to ssd_ready; 0 = never
      int          busy_n;
      int          bp_n;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < SAT) ? v + 1 : v;
   endfunction

   // Reference: a command errors iff the SSD answers later than T cycles (or never).
   function automatic logic [32:0] model_txn(input logic wr, input logic [31:0] addr,
                                             input logic [31:0] wd, input int lat);
      if (lat == 0 || lat > T) begin
         m_err = sat_inc(m_err);
         return {1'b1, 32'h0};
      end
      if (wr) begin
         ref_mem[addr] = wd;
         m_wr = sat_inc(m_wr);
         return {1'b0, 32'h0};
      end
      m_rd = sat_inc(m_rd);
      return {1'b0, ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr)};
   endfunction

   task automatic do_reset();
      rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
      rsp_ready = 0; ssd_ready = 0; ssd_busy = 0; ssd_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_rd = 0; m_wr = 0; m_err = 0; pend = 0;
   endtask

   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input int busy_n, input int bp_n,
                          output logic g_err, output logic [31:0] g_rd);
      int cyc, strobes, strobe_cyc, rsp_cyc, held;
      int bad_addr, bad_idle, bad_hold, bad_busy, bad_kind;
      logic [32:0] first_rsp;
      bit done;
      cyc = 0; strobes = 0; strobe_cyc = -1; rsp_cyc = -1; held = 0;
      bad_addr = 0; bad_idle = 0; bad_hold = 0; bad_busy = 0; bad_kind = 0;
      done = 0; first_rsp = '0; g_err = 1'bx; g_rd = 'x;
      exp_q.push_back(model_txn(wr, addr, wd, lat));
      req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
      ssd_busy = 0; ssd_ready = 0; rsp_ready = 0;
      #1;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      chk("ssd_bus_idle", {ssd_addr, ssd_wdata}, 64'd0);
      while (!done && cyc < 2 * T + 64) begin
         @(posedge clk);
         #1;
         cyc++;
         req_valid = 0; req_write = 1'($urandom_range(0, 1));
         req_addr = $urandom; req_wdata = $urandom;
         ssd_ready = 0; ssd_rdata = $urandom;
         if (pend) begin
            left--;
            if (left == 0) begin
               pend = 0; ssd_ready = 1;
               if (pend_wr) ssd_mem[pend_addr] = pend_wd;
               else ssd_rdata = ssd_mem.exists(pend_addr) ? ssd_mem[pend_addr] : dflt(pend_addr);
            end
         end
         ssd_busy = (cyc <= busy_n);
         #1;
         if (ssd_read || ssd_write) begin
            strobes++; strobe_cyc = cyc;
            if (ssd_busy) bad_busy++;
            if (ssd_write !== wr || ssd_read === ssd_write) bad_kind++;
            if (lat > 0) begin
               pend = 1; left = lat; pend_wr = ssd_write;
               pend_addr = ssd_addr; pend_wd = ssd_wdata;
            end
         end
         if (rsp_valid) begin
            if (rsp_cyc < 0) begin
               rsp_cyc = cyc; first_rsp = {rsp_err, rsp_rdata};
            end else if ({rsp_err, rsp_rdata} !== first_rsp) begin
               bad_hold++;
            end
            if (req_ready || ssd_addr != 0 || ssd_wdata != 0 || ssd_read || ssd_write) bad_idle++;
            held++;
            if (held > bp_n) begin
               rsp_ready = 1; done = 1; g_err = rsp_err; g_rd = rsp_rdata;
            end
         end else if (ssd_addr !== addr || ssd_wdata !== wd || req_ready) begin
            bad_addr++;
         end
      end
      chk("txn_completed", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready = 0; ssd_ready = 0; ssd_busy = 0;
      chk("next_req_ready", {62'd0, req_ready, rsp_valid}, 64'd2);
      chk("strobe_count", 64'(strobes), 64'd1);
      chk("strobe_cycle", 64'(strobe_cyc), 64'(busy_n + 1));
      chk("rsp_latency", 64'(rsp_cyc), 64'(busy_n + 2 + ((lat == 0 || lat > T) ? T : lat)));
      chk("busy_gate", 64'(bad_busy), 64'd0);
      chk("strobe_kind", 64'(bad_kind), 64'd0);
      chk("addr_data_stable", 64'(bad_addr), 64'd0);
      chk("rsp_held", 64'(bad_hold), 64'd0);
      chk("resp_bus_quiet", 64'(bad_idle), 64'd0);
      if (exp_q.size() > 0) chk("scoreboard_rsp", {g_err, g_rd}, exp_q.pop_front());
      chk("counters", {rd_count, wr_count, err_count}, {CW'(m_rd), CW'(m_wr), CW'(m_err)});
   endtask

   initial begin
      logic        g_err;
      logic [31:0] g_rd;
      int          r, bad_rsp;

      tbl[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1000,  0,  0, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 32'h0000_1004, 32'h0,         1000,  0,  0, 1'b0, 32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 32'h0000_2000, 32'h1234_5678,    3,  5,  0, 1'b0, 32'h0};
      tbl[3] = '{1'b0, 32'h0000_3000, 32'h0,            0,  0,  0, 1'b1, 32'h0};
      tbl[4] = '{1'b0, 32'h0000_2000, 32'h0,            1,  0, 10, 1'b0, 32'h1234_5678};
      tbl[5] = '{1'b0, 32'h0000_2000, 32'h0,            T,  0,  0, 1'b0, 32'h1234_5678};
      tbl[6] = '{1'b0, 32'h0000_1004, 32'h0,        T + 1,  0,  0, 1'b1, 32'h0};
      tbl[7] = '{1'b1, 32'h0000_1004, 32'h0BAD_F00D,    T,  1,  2, 1'b0, 32'h0};
      tbl[8] = '{1'b0, 32'h0000_1004, 32'h0,            2,  2,  3, 1'b0, 32'h0BAD_F00D};

      do_reset();
      chk("reset_handshake", {60'd0, req_ready, rsp_valid, rsp_err, 1'b0}, 64'h8);
      chk("reset_strobes", {62'd0, ssd_read, ssd_write}, 64'd0);
      chk("reset_bus", {ssd_addr, rsp_rdata}, 64'd0);
      chk("reset_counters", {58'd0, rd_count, wr_count, err_count}, 64'd0);
      chk("reset_state", 64'(dbg_state), 64'd0);

      foreach (tbl[i]) begin
         run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat, tbl[i].busy_n, tbl[i].bp_n,
                 g_err, g_rd);
         chk($sformatf("vec%0d_rsp", i), {g_err, g_rd}, {tbl[i].exp_err, tbl[i].exp_rd});
      end

      // Reset while waiting on the SSD: back to idle, counters cleared, no response.
      req_valid = 1; req_write = 0; req_addr = 32'h40; req_wdata = 32'h0;
      @(posedge clk);
      #1;
      req_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("wait_addr", 64'(ssd_addr), 64'h40);
      rst = 1;
      @(posedge clk);
      #1;
      chk("rst_wait_strobes", {62'd0, ssd_read, ssd_write}, 64'd0);
      chk("rst_wait_bus", {ssd_addr, ssd_wdata}, 64'd0);
      chk("rst_wait_counters", {58'd0, rd_count, wr_count, err_count}, 64'd0);
      rst = 0;
      m_rd = 0; m_wr = 0; m_err = 0;
      bad_rsp = 0;
      for (int c = 0; c < 20; c++) begin
         ssd_ready = (c == 3);
         ssd_rdata = $urandom;
         @(posedge clk);
         #1;
         if (rsp_valid || !req_ready || rd_count != 0) bad_rsp = bad_rsp + 1;
      end
      ssd_ready = 0;
      chk("no_rsp_after_reset", 64'(bad_rsp), 64'd0);

      for (int k = 0; k < 5; k++)
         run_txn(1'b0, 32'h0000_1008, 32'h0, 2, 0, 0, g_err, g_rd);
      chk("rd_count_saturates", 64'(rd_count), 64'd3);

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 15);
         run_txn(1'($urandom_range(0, 1)), 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4,
                 $urandom, (r == 0) ? 0 : $urandom_range(1, 12),
                 $urandom_range(0, 3), $urandom_range(0, 3), g_err, g_rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
